// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine front-end: money width, coin
// values, request modes and the collector state encoding.
package vm_pkg;

  localparam int MONEY_W = 7;

  localparam int COIN_VAL_0 = 1;
  localparam int COIN_VAL_1 = 5;
  localparam int COIN_VAL_2 = 10;
  localparam int COIN_VAL_3 = 25;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_BUY  = 2'd1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_REQUEST = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_REFUND  = 3'd4;

  function automatic logic [MONEY_W-1:0] coin_to_value(input logic [1:0] code);
    logic [MONEY_W-1:0] value;
    case (code)
      2'd0:    value = MONEY_W'(COIN_VAL_0);
      2'd1:    value = MONEY_W'(COIN_VAL_1);
      2'd2:    value = MONEY_W'(COIN_VAL_2);
      default: value = MONEY_W'(COIN_VAL_3);
    endcase
    return value;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Inactivity counter: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // A clear in the same cycle as the last count wins, so activity always
  // restarts the full window.
  assign expire = enable && !clear && (count == LAST);

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/coin_credit_collector.sv
// Coin front-end for the vending core: accumulates credit, issues one purchase
// request per selection and pays out change or a full refund.
module coin_credit_collector #(
  parameter int MONEY_W        = vm_pkg::MONEY_W,
  parameter int MAX_CREDIT     = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_valid,
  input  logic [1:0]         coin_value,
  input  logic               sel_valid,
  input  logic [2:0]         sel_type,
  input  logic [3:0]         sel_amount,
  input  logic               cancel,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [1:0]         mode,
  output logic [MONEY_W-1:0] customer_money,
  output logic [2:0]         supply_type,
  output logic [3:0]         customer_amount,
  input  logic               resp_valid,
  input  logic [6:0]         resp_error,
  input  logic [MONEY_W-1:0] resp_change,
  output logic               refund_valid,
  output logic [MONEY_W-1:0] refund_amount,
  output logic               coin_reject,
  output logic               busy
);

  import vm_pkg::*;

  logic [2:0]         state, state_d;
  logic [MONEY_W-1:0] credit, credit_d;
  logic [2:0]         sel_type_d;
  logic [3:0]         sel_amount_d;
  logic               req_valid_d;
  logic               refund_valid_d;
  logic [MONEY_W-1:0] refund_amount_d;

  logic [MONEY_W:0]   coin_ext;
  logic [MONEY_W:0]   coin_sum;
  logic               collecting;
  logic               coin_ok;
  logic [MONEY_W-1:0] next_credit;
  logic [MONEY_W-1:0] resp_refund;

  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  // One extra bit on the sum so an over-limit coin is caught before wrapping.
  always_comb begin
    coin_ext     = (MONEY_W + 1)'(coin_to_value(coin_value));
    coin_sum     = {1'b0, credit} + coin_ext;
    collecting   = (state == ST_IDLE) || (state == ST_COLLECT);
    coin_ok      = coin_valid && collecting &&
                   (coin_sum <= (MONEY_W + 1)'(MAX_CREDIT));
    next_credit  = coin_ok ? coin_sum[MONEY_W-1:0] : credit;
    resp_refund  = (resp_error != '0) ? credit : resp_change;
    timer_enable = (state == ST_COLLECT);
    timer_clear  = !timer_enable || coin_valid || sel_valid;
  end

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(timer_enable),
    .expire(timer_expire)
  );

  // NOTE: next-state logic uses blocking assignments and gives every target a
  // default first, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    state_d         = state;
    credit_d        = credit;
    sel_type_d      = supply_type;
    sel_amount_d    = customer_amount;
    req_valid_d     = req_valid;
    refund_valid_d  = 1'b0;
    refund_amount_d = refund_amount;

    case (state)
      ST_IDLE: begin
        if (coin_ok) begin
          credit_d = next_credit;
          state_d  = ST_COLLECT;
        end
      end

      // Cancel outranks selection; a coin in the same cycle is still credited.
      ST_COLLECT: begin
        credit_d = next_credit;
        if (cancel || timer_expire) begin
          state_d         = ST_REFUND;
          refund_valid_d  = (next_credit != '0);
          refund_amount_d = next_credit;
        end else if (sel_valid) begin
          sel_type_d   = sel_type;
          sel_amount_d = sel_amount;
          req_valid_d  = 1'b1;
          state_d      = ST_REQUEST;
        end
      end

      ST_REQUEST: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (resp_valid) begin
          refund_valid_d  = (resp_refund != '0);
          refund_amount_d = resp_refund;
          state_d         = ST_REFUND;
        end
      end

      ST_REFUND: begin
        credit_d        = '0;
        refund_amount_d = '0;
        state_d         = ST_IDLE;
      end

      default: begin
        credit_d    = '0;
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      credit          <= '0;
      supply_type     <= '0;
      customer_amount <= '0;
      req_valid       <= 1'b0;
      mode            <= MODE_NONE;
      refund_valid    <= 1'b0;
      refund_amount   <= '0;
      coin_reject     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_d;
      credit          <= credit_d;
      supply_type     <= sel_type_d;
      customer_amount <= sel_amount_d;
      req_valid       <= req_valid_d;
      mode            <= req_valid_d ? MODE_BUY : MODE_NONE;
      refund_valid    <= refund_valid_d;
      refund_amount   <= refund_amount_d;
      coin_reject     <= coin_valid && !coin_ok;
      busy            <= (state_d == ST_REQUEST) || (state_d == ST_WAIT) ||
                         (state_d == ST_REFUND);
    end
  end

  assign customer_money = credit;

endmodule

// File: tb/tb_coin_credit_collector.sv
// Self-checking bench for coin_credit_collector: directed scenarios plus
// randomized transactions checked against a plain arithmetic credit model.
module tb_coin_credit_collector;

  localparam int MONEY_W        = 7;
  localparam int MAX_CREDIT     = 100;
  localparam int TIMEOUT_CYCLES = 8;

  logic               clk;
  logic               rst;
  logic               coin_valid;
  logic [1:0]         coin_value;
  logic               sel_valid;
  logic [2:0]         sel_type;
  logic [3:0]         sel_amount;
  logic               cancel;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         mode;
  logic [MONEY_W-1:0] customer_money;
  logic [2:0]         supply_type;
  logic [3:0]         customer_amount;
  logic               resp_valid;
  logic [6:0]         resp_error;
  logic [MONEY_W-1:0] resp_change;
  logic               refund_valid;
  logic [MONEY_W-1:0] refund_amount;
  logic               coin_reject;
  logic               busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  coin_credit_collector #(
    .MONEY_W(MONEY_W),
    .MAX_CREDIT(MAX_CREDIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin_valid(coin_valid),
    .coin_value(coin_value),
    .sel_valid(sel_valid),
    .sel_type(sel_type),
    .sel_amount(sel_amount),
    .cancel(cancel),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .mode(mode),
    .customer_money(customer_money),
    .supply_type(supply_type),
    .customer_amount(customer_amount),
    .resp_valid(resp_valid),
    .resp_error(resp_error),
    .resp_change(resp_change),
    .refund_valid(refund_valid),
    .refund_amount(refund_amount),
    .coin_reject(coin_reject),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  function automatic int coin_worth(input logic [1:0] code);
    case (code)
      2'd0:    return 1;
      2'd1:    return 5;
      2'd2:    return 10;
      default: return 25;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    coin_valid  = 1'b0;
    coin_value  = 2'd0;
    sel_valid   = 1'b0;
    sel_type    = 3'd0;
    sel_amount  = 4'd0;
    cancel      = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_error  = 7'd0;
    resp_change = '0;
  endtask

  task automatic put_coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_value = code;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_quiet();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({req_valid, mode, customer_money, supply_type, customer_amount, refund_valid,
         refund_amount, coin_reject, busy} !== 27'd0)
      $display("FAIL reset_outputs: got req=%0d mode=%0d money=%0d refund=%0d busy=%0d want all 0",
               req_valid, mode, customer_money, refund_valid, busy);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({req_valid, customer_money, refund_valid, coin_reject, busy} !== 11'd0)
      $display("FAIL reset_idle: got req=%0d money=%0d busy=%0d want 0", req_valid, customer_money, busy);
    else pass_cnt++;
  endtask

  task automatic test_purchase_change();
    logic [1:0] codes [3];
    int exp_money;
    codes[0] = 2'd3; codes[1] = 2'd3; codes[2] = 2'd2;
    exp_money = 0;
    for (int i = 0; i < 3; i++) begin
      put_coin(codes[i]);
      exp_money += coin_worth(codes[i]);
      total_cnt++;
      if (coin_reject !== 1'b0 || customer_money !== MONEY_W'(exp_money))
        $display("FAIL purchase_coin%0d: got money=%0d reject=%0d want money=%0d reject=0",
                 i, customer_money, coin_reject, exp_money);
      else pass_cnt++;
    end
    req_ready = 1'b1;
    sel_valid = 1'b1; sel_type = 3'd2; sel_amount = 4'd3;
    tick();
    sel_valid = 1'b0;
    total_cnt++;
    if ({req_valid, mode, customer_money, supply_type, customer_amount, busy} !==
        {1'b1, 2'd1, 7'd60, 3'd2, 4'd3, 1'b1})
      $display("FAIL purchase_request: got v=%0d mode=%0d money=%0d type=%0d amt=%0d want 1/1/60/2/3",
               req_valid, mode, customer_money, supply_type, customer_amount);
    else pass_cnt++;
    tick();
    req_ready = 1'b0;
    total_cnt++;
    if (req_valid !== 1'b0 || mode !== 2'd0 || busy !== 1'b1)
      $display("FAIL purchase_handshake: got v=%0d mode=%0d busy=%0d want 0/0/1", req_valid, mode, busy);
    else pass_cnt++;
    resp_valid = 1'b1; resp_error = 7'd0; resp_change = 7'd15;
    tick();
    resp_valid = 1'b0;
    total_cnt++;
    if (refund_valid !== 1'b1 || refund_amount !== 7'd15)
      $display("FAIL purchase_refund: got v=%0d amt=%0d want 1/15", refund_valid, refund_amount);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (refund_valid !== 1'b0 || busy !== 1'b0 || customer_money !== 7'd0)
      $display("FAIL purchase_done: got v=%0d busy=%0d money=%0d want 0/0/0", refund_valid, busy, customer_money);
    else pass_cnt++;
  endtask

  task automatic test_rejected();
    put_coin(2'd2);
    req_ready = 1'b1;
    sel_valid = 1'b1; sel_type = 3'd1; sel_amount = 4'd1;
    tick();
    sel_valid = 1'b0;
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1; resp_error = 7'd3; resp_change = 7'd99;
    tick();
    resp_valid = 1'b0; resp_error = 7'd0;
    total_cnt++;
    if (refund_valid !== 1'b1 || refund_amount !== 7'd10)
      $display("FAIL rejected_refund: got v=%0d amt=%0d want 1/10", refund_valid, refund_amount);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) put_coin(2'd3);
    total_cnt++;
    if (customer_money !== 7'd100 || coin_reject !== 1'b0)
      $display("FAIL overflow_full: got money=%0d reject=%0d want 100/0", customer_money, coin_reject);
    else pass_cnt++;
    put_coin(2'd0);
    total_cnt++;
    if (coin_reject !== 1'b1 || customer_money !== 7'd100)
      $display("FAIL overflow_reject: got reject=%0d money=%0d want 1/100", coin_reject, customer_money);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (coin_reject !== 1'b0)
      $display("FAIL overflow_pulse_width: got reject=%0d want 0", coin_reject);
    else pass_cnt++;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    total_cnt++;
    if (refund_valid !== 1'b1 || refund_amount !== 7'd100)
      $display("FAIL overflow_cancel: got v=%0d amt=%0d want 1/100", refund_valid, refund_amount);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_cancel_with_coin();
    put_coin(2'd1);
    coin_valid = 1'b1; coin_value = 2'd2;
    cancel = 1'b1;
    sel_valid = 1'b1; sel_type = 3'd4; sel_amount = 4'd2;
    req_ready = 1'b1;
    tick();
    coin_valid = 1'b0; cancel = 1'b0; sel_valid = 1'b0;
    total_cnt++;
    if (refund_valid !== 1'b1 || refund_amount !== 7'd15 || req_valid !== 1'b0)
      $display("FAIL cancel_refund: got v=%0d amt=%0d req=%0d want 1/15/0", refund_valid, refund_amount, req_valid);
    else pass_cnt++;
    tick();
    req_ready = 1'b0;
    total_cnt++;
    if (refund_valid !== 1'b0 || req_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL cancel_idle: got v=%0d req=%0d busy=%0d want 0/0/0", refund_valid, req_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    put_coin(2'd1);
    for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
      tick();
      if (refund_valid !== 1'b0) early++;
    end
    total_cnt++;
    if (early != 0)
      $display("FAIL timeout_early: got %0d early refund cycles want 0", early);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (refund_valid !== 1'b1 || refund_amount !== 7'd5)
      $display("FAIL timeout_refund: got v=%0d amt=%0d want 1/5", refund_valid, refund_amount);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (refund_valid !== 1'b0 || customer_money !== 7'd0)
      $display("FAIL timeout_clear: got v=%0d money=%0d want 0/0", refund_valid, customer_money);
    else pass_cnt++;
  endtask

  task automatic test_stalled_reset();
    logic [16:0] exp_fields;
    put_coin(2'd2);
    req_ready = 1'b0;
    sel_valid = 1'b1; sel_type = 3'd5; sel_amount = 4'd9;
    tick();
    sel_valid = 1'b0; sel_type = 3'd0; sel_amount = 4'd0;
    exp_fields = {1'b1, 2'd1, 7'd10, 3'd5, 4'd9};
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin coin_valid = 1'b1; coin_value = 2'd3; end
      tick();
      coin_valid = 1'b0;
      total_cnt++;
      if ({req_valid, mode, customer_money, supply_type, customer_amount} !== exp_fields)
        $display("FAIL stall_fields%0d: got v=%0d money=%0d type=%0d amt=%0d want 1/10/5/9",
                 i, req_valid, customer_money, supply_type, customer_amount);
      else pass_cnt++;
      if (i == 1) begin
        total_cnt++;
        if (coin_reject !== 1'b1)
          $display("FAIL stall_coin_reject: got %0d want 1", coin_reject);
        else pass_cnt++;
      end
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    total_cnt++;
    if (req_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL stall_wait: got req=%0d busy=%0d want 0/1", req_valid, busy);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({req_valid, mode, customer_money, supply_type, customer_amount, refund_valid,
         refund_amount, coin_reject, busy} !== 27'd0)
      $display("FAIL wait_reset: got req=%0d money=%0d refund=%0d busy=%0d want all 0",
               req_valid, customer_money, refund_valid, busy);
    else pass_cnt++;
    resp_valid = 1'b1; resp_error = 7'd0; resp_change = 7'd5;
    tick();
    resp_valid = 1'b0;
    total_cnt++;
    if (refund_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL wait_reset_noref: got v=%0d busy=%0d want 0/0", refund_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int model;
    int n_coins;
    int worth;
    int ending;
    int exp_refund;
    logic [1:0] code;
    logic [2:0] typ;
    logic [3:0] amt;
    logic [6:0] err;
    logic [MONEY_W-1:0] chg;
    for (int t = 0; t < 25; t++) begin
      model = 0;
      n_coins = $urandom_range(1, 7);
      for (int k = 0; k < n_coins; k++) begin
        code = 2'($urandom_range(0, 3));
        worth = coin_worth(code);
        put_coin(code);
        total_cnt++;
        if (coin_reject !== ((model + worth) > MAX_CREDIT))
          $display("FAIL rand%0d_reject: got %0d for credit %0d + %0d", t, coin_reject, model, worth);
        else pass_cnt++;
        if (model + worth <= MAX_CREDIT) model += worth;
        total_cnt++;
        if (customer_money !== MONEY_W'(model))
          $display("FAIL rand%0d_credit: got %0d want %0d", t, customer_money, model);
        else pass_cnt++;
        repeat ($urandom_range(0, 2)) tick();
      end
      ending = $urandom_range(0, 2);
      if (ending == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          code = 2'($urandom_range(0, 3));
          coin_valid = 1'b1; coin_value = code;
          if (model + coin_worth(code) <= MAX_CREDIT) model += coin_worth(code);
        end
        sel_valid = 1'($urandom_range(0, 1));
        cancel = 1'b1;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
        total_cnt++;
        if (refund_valid !== 1'b1 || refund_amount !== MONEY_W'(model) || req_valid !== 1'b0)
          $display("FAIL rand%0d_cancel: got v=%0d amt=%0d req=%0d want 1/%0d/0",
                   t, refund_valid, refund_amount, req_valid, model);
        else pass_cnt++;
      end else begin
        typ = 3'($urandom_range(0, 7));
        amt = 4'($urandom_range(0, 15));
        sel_valid = 1'b1; sel_type = typ; sel_amount = amt;
        tick();
        sel_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          total_cnt++;
          if ({req_valid, mode, customer_money, supply_type, customer_amount} !==
              {1'b1, 2'd1, MONEY_W'(model), typ, amt})
            $display("FAIL rand%0d_request: got v=%0d money=%0d type=%0d amt=%0d want 1/%0d/%0d/%0d",
                     t, req_valid, customer_money, supply_type, customer_amount, model, typ, amt);
          else pass_cnt++;
          tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        err = (ending == 2) ? 7'($urandom_range(1, 127)) : 7'd0;
        chg = MONEY_W'($urandom_range(0, model));
        if ($urandom_range(0, 3) == 0) chg = '0;
        exp_refund = (err != 7'd0) ? model : int'(chg);
        resp_valid = 1'b1; resp_error = err; resp_change = chg;
        tick();
        resp_valid = 1'b0; resp_error = 7'd0;
        total_cnt++;
        if (refund_valid !== (exp_refund != 0) ||
            (exp_refund != 0 && refund_amount !== MONEY_W'(exp_refund)))
          $display("FAIL rand%0d_refund: got v=%0d amt=%0d want amount %0d", t, refund_valid, refund_amount, exp_refund);
        else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (refund_valid !== 1'b0 || busy !== 1'b0 || customer_money !== '0)
        $display("FAIL rand%0d_idle: got v=%0d busy=%0d money=%0d want 0/0/0", t, refund_valid, busy, customer_money);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_quiet();
    test_reset();
    test_purchase_change();
    test_rejected();
    test_overflow();
    test_cancel_with_coin();
    test_timeout();
    test_stalled_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/coin_credit_collector.md
# coin_credit_collector

Upstream front-end of the vending machine core (`Main`). It accepts coin pulses and accumulates them into a 7-bit customer credit, then captures an item selection. It issues a single purchase request carrying `mode`, `customer_money`, `supply_type` and `customer_amount`, waits for the core's verdict, and returns change or a full refund. Cancel and inactivity timeout return the whole credit.

## Interface
- `MONEY_W`, 7, width of credit, price and refund values
- `MAX_CREDIT`, 100, highest credit accepted; coins that would exceed it are rejected
- `TIMEOUT_CYCLES`, 1000, idle cycles in COLLECT before an automatic refund
- `clk`  in  1  system clock; one clock domain; rising edge
- `rst`  in  1  synchronous, active-high reset
- `coin_valid`  in  1  one-cycle coin insertion pulse
- `coin_value`  in  2  coin code: 0→1, 1→5, 2→10, 3→25 units
- `sel_valid`  in  1  one-cycle selection pulse
- `sel_type`  in  3  item type
- `sel_amount`  in  4  item quantity
- `cancel`  in  1  customer cancel pulse
- `req_valid`  out  1  purchase request valid
- `req_ready`  in  1  core accepts request
- `mode`  out  2  constant 2'd1 (purchase) while `req_valid`; 2'd0 otherwise
- `customer_money`  out  MONEY_W  latched credit
- `supply_type`  out  3  latched `sel_type`
- `customer_amount`  out  4  latched `sel_amount`
- `resp_valid`  in  1  one-cycle verdict pulse from the core
- `resp_error`  in  7  0 = success; non-zero = rejected
- `resp_change`  in  MONEY_W  change owed on success
- `refund_valid`  out  1  one-cycle refund pulse
- `refund_amount`  out  MONEY_W  value paid out; valid only with `refund_valid`
- `coin_reject`  out  1  one-cycle pulse; coin was not credited
- `busy`  out  1  high in REQUEST, WAIT and REFUND

## Operation
- **States:** IDLE, COLLECT, REQUEST, WAIT, REFUND.
- **IDLE:** credit = 0. An accepted coin moves to COLLECT. `sel_valid` and `cancel` are ignored.
- **COLLECT, coins:** credit += value when credit + value ≤ MAX_CREDIT. Otherwise credit is unchanged and `coin_reject` pulses.
- **COLLECT, selection:** `sel_valid` latches type and amount, then moves to REQUEST.
- **COLLECT, cancel:** `cancel` moves to REFUND with the full credit.
- **COLLECT, timeout:** the idle counter reaching TIMEOUT_CYCLES−1 moves to REFUND with the full credit. The counter clears on every coin or selection.
- **Same-cycle coin and select:** the coin is added first, and the request carries the updated credit.
- **Same-cycle cancel and select (or coin):** cancel wins. The coin is still credited, so it is included in the refund.
- **REQUEST:** `req_valid` = 1 and all request fields are held stable until `req_valid && req_ready`, then move to WAIT. `cancel` is ignored.
- **WAIT:** on `resp_valid`, set refund = credit if `resp_error` ≠ 0, else refund = `resp_change`. Move to REFUND.
- **REFUND:**
  - If the refund value is non-zero, `refund_valid` pulses for exactly one cycle.
  - If it is zero, there is no pulse.
  - Credit clears and the state returns to IDLE.
- **Coins outside IDLE/COLLECT:** a coin arriving in REQUEST, WAIT or REFUND is rejected with a `coin_reject` pulse.
- **Arithmetic:** computed at MONEY_W+1 bits for the overflow check. MAX_CREDIT ≤ 2^MONEY_W−1.

## Timing
- **Reset values:** all outputs 0, credit 0, state IDLE.
- **Reset mid-operation:** discards credit with no refund pulse and drops `req_valid` immediately on the next edge.
- **Coin latency:** `coin_valid` at edge N → credit visible on `customer_money` after N+1. `coin_reject` is high in the cycle after N.
- **Select latency:** `sel_valid` at N → `req_valid` high from N+1.
- **Request handshake:** the transfer cycle is the edge where `req_valid && req_ready`. `req_valid` is low the following cycle. Back-to-back requests are impossible.
- **Response latency:** `resp_valid` at M → `refund_valid` high in cycle M+1 only.
- **Cancel latency:** `cancel` at N → `refund_valid` in N+1, and IDLE at N+2.
- **Timeout latency:** the refund pulse fires exactly TIMEOUT_CYCLES cycles after the last coin or selection.
- **Registered outputs:** all outputs are registered; there is no combinational path from input to output.

## Structure
- **Shared package `vm_pkg`:**
  - coin-code → value constants
  - `MODE_BUY` = 2'd1
  - state encoding
  - `MONEY_W`
- **Sub-module `idle_timer`:** clear, enable and expire signals, parameterised by TIMEOUT_CYCLES.

## Test plan
- **Purchase with change:**
  - Stimulus: coins 25, 25, 10, then select type 2 amount 3; `req_ready`=1; response `resp_error`=0, `resp_change`=15.
  - Required: request `customer_money`=60, `supply_type`=2, `customer_amount`=3, `mode`=1, then one refund pulse of 15.
- **Rejected purchase:** credit 10 then select; response `resp_error`=7'd3 → `refund_amount`=10.
- **Credit overflow:** coins 25×4 = 100, then a coin of 1 → `coin_reject` pulse, credit stays 100.
- **Cancel with coin:** credit 5, then same-cycle coin 10 + cancel + select → no request issued; refund 15 in the next cycle.
- **Timeout:** credit 5 with TIMEOUT_CYCLES=8 → refund 5 exactly 8 cycles after the coin.
- **Stalled request:** `req_ready` held low for 4 cycles, with a coin arriving meanwhile → fields stable, coin rejected. Reset asserted in WAIT → all outputs 0 next cycle, no refund.
